// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler
// Global ghost mode controller. Runs the scatter/chase schedule, the
// per-ghost frightened state after a power pellet, the direction-reversal
// pulse on mode changes, and the ghost-eaten combo count used for scoring.
//
// Ports:
//   clk             system clock
//   reset           synchronous active-high reset
//   tick            one-cycle game-step pulse (durations are counted in ticks)
//   pause           while high, tick is ignored; all other inputs still act
//   powerPellet     one-cycle pulse: pacman ate a power pellet
//   ghostEaten[3:0] per-ghost collision pulse (0 blinky, 1 pinky, 2 inky, 3 clyde)
//   mode[1:0]       00 scatter, 01 chase, 10 frightened
//   frightenedGhost per-ghost frightened flag
//   flash           frightened and inside the last FLASH_TICKS ticks
//   reverseDir      one-cycle pulse: ghosts reverse direction
//   phase[2:0]      completed scatter periods, saturating at NUM_SCATTER
//   eatCombo[1:0]   ghosts eaten this frightened period, saturating at 3
// All outputs are registered; an input sampled at edge N shows at edge N+1.
module ghost_mode_scheduler #(
  parameter int SCATTER_TICKS = 7,
  parameter int CHASE_TICKS   = 20,
  parameter int NUM_SCATTER   = 4,
  parameter int FRIGHT_TICKS  = 6,
  parameter int FLASH_TICKS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       powerPellet,
  input  logic [3:0] ghostEaten,
  output logic [1:0] mode,
  output logic [3:0] frightenedGhost,
  output logic       flash,
  output logic       reverseDir,
  output logic [2:0] phase,
  output logic [1:0] eatCombo
);

  localparam int BASE_MAX = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int BCW      = $clog2(BASE_MAX + 1);
  localparam int FCW      = $clog2(FRIGHT_TICKS + 1);

  localparam logic [BCW-1:0] SCATTER_LAST = BCW'(SCATTER_TICKS - 1);
  localparam logic [BCW-1:0] CHASE_LAST   = BCW'(CHASE_TICKS - 1);
  localparam logic [FCW-1:0] FRIGHT_LAST  = FCW'(FRIGHT_TICKS - 1);
  localparam logic [FCW-1:0] FLASH_START  = FCW'(FRIGHT_TICKS - FLASH_TICKS);
  localparam logic [2:0]     PHASE_MAX    = 3'(NUM_SCATTER);

  typedef enum logic [1:0] {
    ST_SCATTER     = 2'd0,
    ST_CHASE       = 2'd1,
    ST_CHASE_FINAL = 2'd2,
    ST_FRIGHT      = 2'd3
  } state_t;

  // state_q is the live state; base_state_q remembers the schedule state
  // to return to once the frightened period ends.
  state_t           state_q, state_d;
  state_t           base_state_q, base_state_d;
  logic [BCW-1:0]   base_cnt_q, base_cnt_d;
  logic [FCW-1:0]   fright_cnt_q, fright_cnt_d;
  logic [3:0]       frightened_q, frightened_d;
  logic [1:0]       combo_q, combo_d;
  logic [2:0]       phase_q, phase_d;
  logic             reverse_q, reverse_d;
  logic [1:0]       mode_q, mode_d;
  logic             flash_q, flash_d;

  logic             etick;
  logic [3:0]       eat_hits;
  logic [2:0]       eat_count;
  logic [2:0]       combo_sum;
  logic [1:0]       combo_sat;
  logic [2:0]       phase_inc;
  logic             fright_expire;

  assign etick = tick & ~pause;

  // Only ghosts that are still frightened can be eaten; other collisions
  // are a pacman death and are handled outside this block.
  assign eat_hits  = ghostEaten & frightened_q;
  assign eat_count = {2'b00, eat_hits[0]} + {2'b00, eat_hits[1]}
                   + {2'b00, eat_hits[2]} + {2'b00, eat_hits[3]};
  assign combo_sum = {1'b0, combo_q} + eat_count;
  assign combo_sat = (combo_sum > 3'd3) ? 2'd3 : combo_sum[1:0];

  assign phase_inc     = (phase_q == PHASE_MAX) ? phase_q : phase_q + 3'd1;
  assign fright_expire = etick && (fright_cnt_q == FRIGHT_LAST);

  always_comb begin
    state_d      = state_q;
    base_state_d = base_state_q;
    base_cnt_d   = base_cnt_q;
    fright_cnt_d = fright_cnt_q;
    frightened_d = frightened_q;
    combo_d      = combo_q;
    phase_d      = phase_q;
    reverse_d    = 1'b0;
    mode_d       = 2'b00;
    flash_d      = 1'b0;

    if (powerPellet) begin
      // A pellet wins over every other event this cycle: eats, fright
      // expiry and an expiring base period (the base tick is dropped).
      state_d      = ST_FRIGHT;
      fright_cnt_d = '0;
      frightened_d = 4'hF;
      combo_d      = 2'd0;
      reverse_d    = 1'b1;
    end else if (state_q == ST_FRIGHT) begin
      frightened_d = frightened_q & ~eat_hits;
      combo_d      = combo_sat;
      if (etick) begin
        fright_cnt_d = fright_cnt_q + FCW'(1);
      end
      // Exit happens on the same edge that expiry or the last eat is seen,
      // so both together still give a single exit.
      if (fright_expire || (frightened_d == 4'h0)) begin
        state_d      = base_state_q;
        frightened_d = 4'h0;
        combo_d      = 2'd0;
        fright_cnt_d = '0;
      end
    end else if (etick) begin
      case (state_q)
        ST_SCATTER: begin
          if (base_cnt_q == SCATTER_LAST) begin
            base_cnt_d = '0;
            phase_d    = phase_inc;
            reverse_d  = 1'b1;
            state_d    = (phase_inc == PHASE_MAX) ? ST_CHASE_FINAL : ST_CHASE;
          end else begin
            base_cnt_d = base_cnt_q + BCW'(1);
          end
        end
        ST_CHASE: begin
          if (base_cnt_q == CHASE_LAST) begin
            base_cnt_d = '0;
            reverse_d  = 1'b1;
            state_d    = ST_SCATTER;
          end else begin
            base_cnt_d = base_cnt_q + BCW'(1);
          end
        end
        default: begin
          base_cnt_d = '0;
        end
      endcase
      base_state_d = state_d;
    end

    case (state_d)
      ST_SCATTER: mode_d = 2'b00;
      ST_FRIGHT:  mode_d = 2'b10;
      default:    mode_d = 2'b01;
    endcase

    flash_d = (state_d == ST_FRIGHT) && (fright_cnt_d >= FLASH_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SCATTER;
      base_state_q <= ST_SCATTER;
      base_cnt_q   <= '0;
      fright_cnt_q <= '0;
      frightened_q <= 4'h0;
      combo_q      <= 2'd0;
      phase_q      <= 3'd0;
      reverse_q    <= 1'b0;
      mode_q       <= 2'b00;
      flash_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_state_q <= base_state_d;
      base_cnt_q   <= base_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      frightened_q <= frightened_d;
      combo_q      <= combo_d;
      phase_q      <= phase_d;
      reverse_q    <= reverse_d;
      mode_q       <= mode_d;
      flash_q      <= flash_d;
    end
  end

  assign mode            = mode_q;
  assign frightenedGhost = frightened_q;
  assign flash           = flash_q;
  assign reverseDir      = reverse_q;
  assign phase           = phase_q;
  assign eatCombo        = combo_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Testbench for ghost_mode_scheduler. Every cycle the stimulus process
// drives inputs, advances a behavioural reference model and queues the
// expected outputs; a monitor process pops and compares one entry per cycle.
module tb_ghost_mode_scheduler;

  localparam int S  = 3;
  localparam int C  = 5;
  localparam int NS = 2;
  localparam int F  = 4;
  localparam int FL = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       powerPellet = 1'b0;
  logic [3:0] ghostEaten = 4'h0;
  logic [1:0] mode;
  logic [3:0] frightenedGhost;
  logic       flash;
  logic       reverseDir;
  logic [2:0] phase;
  logic [1:0] eatCombo;

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .SCATTER_TICKS(S),
    .CHASE_TICKS  (C),
    .NUM_SCATTER  (NS),
    .FRIGHT_TICKS (F),
    .FLASH_TICKS  (FL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .pause          (pause),
    .powerPellet    (powerPellet),
    .ghostEaten     (ghostEaten),
    .mode           (mode),
    .frightenedGhost(frightenedGhost),
    .flash          (flash),
    .reverseDir     (reverseDir),
    .phase          (phase),
    .eatCombo       (eatCombo)
  );

  // Expected output word: {mode, frightenedGhost, flash, reverseDir, phase, eatCombo}
  logic [12:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: schedule position 0=scatter, 1=chase, 2=final chase.
  int         m_base  = 0;
  int         m_bcnt  = 0;
  int         m_fcnt  = 0;
  int         m_phase = 0;
  int         m_combo = 0;
  bit         m_fr    = 0;
  bit         m_rev   = 0;
  logic [3:0] m_fg    = 4'h0;

  task automatic model(input bit r, input bit t, input bit p, input bit pp,
                       input logic [3:0] ge);
    bit et;
    int limit;
    et    = t && !p;
    m_rev = 0;
    if (r) begin
      m_base = 0; m_bcnt = 0; m_fcnt = 0; m_phase = 0; m_combo = 0;
      m_fr = 0; m_fg = 4'h0;
    end else if (pp) begin
      m_fr = 1; m_fcnt = 0; m_fg = 4'hF; m_combo = 0; m_rev = 1;
    end else if (m_fr) begin
      for (int i = 0; i < 4; i++) begin
        if (ge[i] && m_fg[i]) begin
          m_fg[i] = 1'b0;
          m_combo = m_combo + 1;
        end
      end
      if (m_combo > 3) m_combo = 3;
      if (et) m_fcnt = m_fcnt + 1;
      if (m_fcnt == F || m_fg == 4'h0) begin
        m_fr = 0; m_fg = 4'h0; m_combo = 0; m_fcnt = 0;
      end
    end else if (et && m_base != 2) begin
      m_bcnt = m_bcnt + 1;
      limit  = (m_base == 0) ? S : C;
      if (m_bcnt == limit) begin
        m_bcnt = 0;
        m_rev  = 1;
        if (m_base == 0) begin
          if (m_phase < NS) m_phase = m_phase + 1;
          m_base = (m_phase == NS) ? 2 : 1;
        end else begin
          m_base = 0;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [1:0] md;
    logic       fl;
    md = m_fr ? 2'b10 : ((m_base == 0) ? 2'b00 : 2'b01);
    fl = m_fr && (m_fcnt >= F - FL);
    return {md, m_fg, fl, m_rev, 3'(m_phase), 2'(m_combo)};
  endfunction

  task automatic step(input bit r, input bit t, input bit p, input bit pp,
                      input logic [3:0] ge);
    @(negedge clk);
    reset       = r;
    tick        = t;
    pause       = p;
    powerPellet = pp;
    ghostEaten  = ge;
    model(r, t, p, pp, ge);
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'h0);
  endtask

  // Each tick is followed by an idle cycle so every edge is visible.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 4'h0);
      idle();
    end
  endtask

  task automatic pellet();
    step(0, 0, 0, 1, 4'h0);
  endtask

  task automatic eat(input logic [3:0] ge);
    step(0, 0, 0, 0, ge);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 4'h0);
    idle();
  endtask

  // Monitor: one comparison per cycle, 1 time unit after the active edge.
  initial begin
    logic [12:0] e;
    logic [12:0] a;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {mode, frightenedGhost, flash, reverseDir, phase, eatCombo};
        n_cmp = n_cmp + 1;
        if (a !== e) begin
          n_bad = n_bad + 1;
          $display("FAIL outputs cyc %0d: got mode=%b fg=%b flash=%b rev=%b phase=%0d combo=%0d, expected mode=%b fg=%b flash=%b rev=%b phase=%0d combo=%0d",
                   cyc, a[12:11], a[10:7], a[6], a[5], a[4:2], a[1:0],
                   e[12:11], e[10:7], e[6], e[5], e[4:2], e[1:0]);
        end else begin
          $display("cyc %0d ok mode=%b fg=%b flash=%b rev=%b phase=%0d combo=%0d",
                   cyc, a[12:11], a[10:7], a[6], a[5], a[4:2], a[1:0]);
        end
      end
    end
  end

  initial begin
    bit         r, t, p, pp;
    logic [3:0] ge;
    int         wait_cnt;

    // Reset state and the full schedule through to permanent chase.
    do_reset();
    ticks(3);
    ticks(5);
    ticks(3);
    ticks(40);

    // Fright from CHASE with baseCnt=2, expiry, then resume the frozen count.
    do_reset();
    ticks(3);
    ticks(2);
    pellet();
    idle();
    ticks(3);
    ticks(1);
    ticks(3);

    // Eating: 0100, 0011, then the last ghost gives an immediate exit.
    pellet();
    eat(4'b0100);
    eat(4'b0011);
    eat(4'b1000);
    idle();

    // Pellet + tick + eat on the cycle fright would expire.
    pellet();
    ticks(3);
    step(0, 1, 0, 1, 4'b0001);
    idle();
    ticks(4);

    // Last ghost eaten on the same tick as expiry.
    pellet();
    eat(4'b0111);
    ticks(3);
    step(0, 1, 0, 0, 4'b1000);
    idle();

    // Pellet on a base-period expiring tick drops that tick.
    do_reset();
    ticks(2);
    step(0, 1, 0, 1, 4'h0);
    ticks(4);
    ticks(1);

    // Pause freezes counters; eat on an already-eaten ghost is ignored.
    do_reset();
    ticks(1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 4'h0);
      step(0, 0, 1, 0, 4'h0);
    end
    pellet();
    step(0, 1, 1, 0, 4'b0001);
    eat(4'b0001);
    ticks(4);

    // Reset during fright with phase=1, then a normal scatter->chase.
    do_reset();
    ticks(3);
    ticks(5);
    pellet();
    ticks(1);
    step(1, 0, 0, 0, 4'h0);
    idle();
    ticks(3);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      t  = ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 6) == 0);
      pp = ($urandom_range(0, 24) == 0);
      ge = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(r, t, p, pp, ge);
    end
    idle();

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt = wait_cnt + 1;
    end
    #2;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
- Global ghost mode controller that sequences all four ghost behaviour instances (blinky/pinky/inky/clyde).
- Drives the scatter/chase alternation schedule and the per-ghost frightened state after a power pellet.
- Emits a direction-reversal pulse on mode changes and a ghost-eaten combo count for scoring.
- The target selection inside each ghost behaviour block is gated by `mode` and `frightenedGhost`.

Parameters:
- SCATTER_TICKS, 7: game ticks per scatter period.
- CHASE_TICKS, 20: game ticks per non-final chase period.
- NUM_SCATTER, 4: number of scatter periods before permanent chase.
- FRIGHT_TICKS, 6: game ticks of frightened mode per pellet.
- FLASH_TICKS, 2: final frightened ticks during which `flash` is high (FLASH_TICKS < FRIGHT_TICKS).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle game-step pulse; all durations are counted in ticks.
- pause, input, 1: while high, `tick` is ignored; all other inputs still act.
- powerPellet, input, 1: one-cycle pulse when pacman eats a power pellet.
- ghostEaten, input, 4: per-ghost one-cycle pulse when pacman collides with that ghost (bit0 blinky, bit1 pinky, bit2 inky, bit3 clyde).
- mode, output, 2: 00 scatter, 01 chase, 10 frightened (11 never driven).
- frightenedGhost, output, 4: per-ghost frightened flag.
- flash, output, 1: high when frightened and in the last FLASH_TICKS ticks.
- reverseDir, output, 1: one-cycle pulse; ghosts reverse direction.
- phase, output, 3: completed scatter periods, saturating at NUM_SCATTER.
- eatCombo, output, 2: ghosts eaten in the current frightened period, saturating at 3.

Behaviour:
- All outputs are registered. Each input sampled at edge N takes effect at edge N+1 (1-cycle latency).
- Reset values: mode=00, frightenedGhost=0000, flash=0, reverseDir=0, phase=0, eatCombo=0; base and fright counters =0; saved base state = SCATTER.
- Reset has priority over all inputs and aborts any state, including FRIGHT, at the next edge.
- States: SCATTER, CHASE, CHASE_FINAL, FRIGHT. A baseState register holds the non-frightened state.
- Effective tick: `etick = tick & ~pause`.
- SCATTER:
  - Count etick in baseCnt.
  - On etick with baseCnt == SCATTER_TICKS-1: baseCnt=0, phase+=1.
  - Next state is CHASE_FINAL if the new phase == NUM_SCATTER, else CHASE. Pulse reverseDir.
- CHASE:
  - On etick with baseCnt == CHASE_TICKS-1: go to SCATTER, baseCnt=0, pulse reverseDir.
- CHASE_FINAL: permanent chase. baseCnt holds at 0; no further reversals from the schedule.
- Entering FRIGHT (powerPellet in any state):
  - frightCnt=0, frightenedGhost=1111, eatCombo=0, mode=10, reverseDir pulse.
  - baseState and baseCnt are frozen for the whole frightened period.
- powerPellet while already in FRIGHT: restart frightCnt=0, frightenedGhost=1111, eatCombo=0, pulse reverseDir.
- In FRIGHT:
  - Count etick in frightCnt.
  - flash = (frightCnt >= FRIGHT_TICKS-FLASH_TICKS).
- Exit from FRIGHT:
  - Triggered by etick with frightCnt == FRIGHT_TICKS-1, or by frightenedGhost becoming 0000.
  - On exit: mode returns to the frozen baseState with baseCnt unchanged; frightenedGhost=0, flash=0, eatCombo=0.
  - No reverseDir pulse on exit.
- ghostEaten:
  - Each asserted bit whose frightenedGhost bit is 1 clears that bit, and eatCombo += 1 per such bit (popcount), saturating at 3.
  - Bits for non-frightened ghosts are ignored; that case is a pacman death, handled elsewhere.
- Simultaneous events:
  - powerPellet beats ghostEaten in the same cycle: all bits are set to 1111 and eatCombo=0.
  - powerPellet beats an expiring base period: baseCnt is not advanced on that tick.
  - powerPellet beats fright expiry in the same cycle: restart, stay in FRIGHT.
  - Eating the last frightened ghost on the same tick as fright expiry: single exit, eatCombo reset.
- reverseDir is never high for two consecutive cycles from a single event. At most one pulse per cycle.
- pause high freezes both counters. powerPellet and ghostEaten are still processed.

Test Plan:
Bench parameters for all scenarios: SCATTER_TICKS=3, CHASE_TICKS=5, NUM_SCATTER=2, FRIGHT_TICKS=4, FLASH_TICKS=1.
- Reset, then 3 ticks -> mode 00→01 one cycle after the 3rd tick, reverseDir pulses once, phase=1. After 5 more ticks -> mode=00 with a reverseDir pulse. After 3 more -> mode=01, phase=2. Then 40 ticks -> mode stays 01 and no reverseDir.
- At baseCnt=2 in CHASE, pulse powerPellet -> mode=10, frightenedGhost=1111, reverseDir pulse. Apply 3 ticks -> flash=1 after the 3rd. 4th tick -> mode=01 and no reverse. Then 3 ticks -> mode=00 (frozen baseCnt resumed at 2).
- In FRIGHT, ghostEaten=0100 then 0011 -> frightenedGhost=1011 then 1000, eatCombo=1 then 3. Then 1000 -> eatCombo stays 3, immediate exit to base mode.
- In FRIGHT at frightCnt=3, powerPellet with tick and ghostEaten=0001 together -> frightCnt=0, frightenedGhost=1111, eatCombo=0, flash=0, single reverseDir pulse.
- In SCATTER, hold pause=1 with 10 tick pulses -> mode and phase unchanged. In FRIGHT, ghostEaten=0001 arriving in a non-frightened bit position -> no change to eatCombo.
- During FRIGHT with phase=1, assert reset for one cycle -> all outputs at reset values on the next edge. The next 3 ticks give a normal scatter→chase transition.
